// File: rtl/tank_pkg.sv
// tank_pkg: shared tank fire-control defaults, shot FSM states and slot allocation helper
package tank_pkg;
  localparam int NUM_BULLETS_DEF = 3;
  localparam int LIFE_FRAMES_DEF = 240;
  localparam int COOLDOWN_FRAMES_DEF = 15;
  localparam int MAX_SLOTS = 8;
  typedef enum logic [1:0] {IDLE, COOLDOWN, WAIT_RELEASE} shot_state_t;
  // Two's-complement trick isolates the lowest set bit: one-hot lowest free slot, 0 if none.
  function automatic logic [MAX_SLOTS-1:0] lowest_free(input logic [MAX_SLOTS-1:0] free);
    return free & (~free + MAX_SLOTS'(1));
  endfunction
endpackage

// File: rtl/bullet_life_timer.sv
// bullet_life_timer: per-slot lifetime countdown and in-flight flag
// Ports: frame_clk/Reset_n (async active-low), load starts a bullet, hit retires it, active = in flight.
module bullet_life_timer import tank_pkg::*; #(
  parameter int LIFE_FRAMES = LIFE_FRAMES_DEF
) (
  input  logic frame_clk,
  input  logic Reset_n,
  input  logic load,
  input  logic hit,
  output logic active
);
  localparam int LW = $clog2(LIFE_FRAMES);
  logic [LW-1:0] life;
  // Hit and expiry share one branch so a coincident pair frees the slot once.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active <= 1'b0;
      life <= '0;
    end else if (load) begin
      active <= 1'b1;
      life <= LW'(LIFE_FRAMES - 1);
    end else if (active && (hit || life == '0)) begin
      active <= 1'b0;
      life <= '0;
    end else if (active) begin
      life <= life - 1'b1;
    end
  end
endmodule

// File: rtl/shot_controller.sv
// shot_controller: turns the shoot key into one-hot bullet create pulses with slot allocation and cooldown
// Ports: frame_clk/Reset_n (async active-low); fire_key, tank_alive, slot_hit in;
// create (one-hot pulse), slot_active, shots_free, fire_blocked out.
// Define SHOT_CONTROLLER_AUTOFIRE_EN to re-fire every cooldown period while the key is held.
module shot_controller import tank_pkg::*; #(
  parameter int NUM_BULLETS = NUM_BULLETS_DEF,
  parameter int LIFE_FRAMES = LIFE_FRAMES_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic                   fire_key,
  input  logic                   tank_alive,
  input  logic [NUM_BULLETS-1:0] slot_hit,
  output logic [NUM_BULLETS-1:0] create,
  output logic [NUM_BULLETS-1:0] slot_active,
  output logic [1:0]             shots_free,
  output logic                   fire_blocked
);
`ifdef SHOT_CONTROLLER_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif
  localparam int CW = $clog2(COOLDOWN_FRAMES);
  shot_state_t state;
  logic [CW-1:0] cd;
  logic key_q, press, fire;
  logic [NUM_BULLETS-1:0] free, load;
  assign press = fire_key & ~key_q;
  // Free mask comes from registered flags, so a slot released on this edge is not reused until the next.
  assign free = ~slot_active;
  assign fire = |free && tank_alive &&
                ((state == IDLE && press) || (AUTOFIRE && state == COOLDOWN && cd == '0 && fire_key));
  assign load = fire ? NUM_BULLETS'(lowest_free(MAX_SLOTS'(free))) : '0;
  assign shots_free = 2'(NUM_BULLETS - $countones(slot_active));
  for (genvar k = 0; k < NUM_BULLETS; k++) begin : g_slot
    // Masking with create drops a hit that lands in the bullet's launch cycle.
    bullet_life_timer #(.LIFE_FRAMES(LIFE_FRAMES)) u_timer (
      .frame_clk,
      .Reset_n,
      .load(load[k]),
      .hit(slot_hit[k] & ~create[k]),
      .active(slot_active[k])
    );
  end
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cd <= '0;
      key_q <= 1'b0;
      create <= '0;
      fire_blocked <= 1'b0;
    end else begin
      key_q <= fire_key;
      create <= load;
      fire_blocked <= 1'b0;
      case (state)
        IDLE:
          if (fire) begin
            cd <= CW'(COOLDOWN_FRAMES - 1);
            state <= COOLDOWN;
          end else if (press && tank_alive) begin
            fire_blocked <= 1'b1;
            state <= WAIT_RELEASE;
          end
        COOLDOWN:
          if (cd != '0) cd <= cd - 1'b1;
          else if (fire) cd <= CW'(COOLDOWN_FRAMES - 1);
          // With autofire and every slot busy, park here at cd==0 until a slot frees or the key drops.
          else if (!(AUTOFIRE && fire_key && tank_alive)) state <= fire_key ? WAIT_RELEASE : IDLE;
        WAIT_RELEASE:
          if (!fire_key) state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shot_controller.sv
// tb_shot_controller: scoreboard-driven bench for shot_controller
module tb_shot_controller;
  logic frame_clk = 1'b0;
  logic Reset_n = 1'b1;
  logic fire_key = 1'b0;
  logic tank_alive = 1'b1;
  logic [2:0] slot_hit = 3'b000;
  logic [2:0] create, slot_active;
  logic [1:0] shots_free;
  logic fire_blocked;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_c;

  always #5 frame_clk = ~frame_clk;

  shot_controller dut (
    .frame_clk(frame_clk),
    .Reset_n(Reset_n),
    .fire_key(fire_key),
    .tank_alive(tank_alive),
    .slot_hit(slot_hit),
    .create(create),
    .slot_active(slot_active),
    .shots_free(shots_free),
    .fire_blocked(fire_blocked)
  );

  // Every create pulse must match the next expected slot; a 2-cycle pulse pops twice and fails.
  always @(negedge frame_clk) begin
    if (create !== 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL create_unexpected: got %b, required no create", create);
      end else begin
        exp_c = exp_q.pop_front();
        if (create !== exp_c) begin
          errors++;
          $display("FAIL create_slot: got %b, required %b", create, exp_c);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    fire_key = 1'b0;
    tank_alive = 1'b1;
    slot_hit = 3'b000;
    Reset_n = 1'b0;
    step(2);
    Reset_n = 1'b1;
    step();
  endtask

  task automatic queue_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_queue: got %0d pending creates, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({create, slot_active, shots_free, fire_blocked} !== {3'b000, 3'b000, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got c=%b a=%b f=%0d b=%b, required c=000 a=000 f=3 b=0",
               create, slot_active, shots_free, fire_blocked);
    end
    step(2);
    Reset_n = 1'b1;
    step(2);
    checks++;
    if ({slot_active, shots_free} !== {3'b000, 2'd3}) begin
      errors++;
      $display("FAIL reset_idle: got a=%b f=%0d, required a=000 f=3", slot_active, shots_free);
    end
  endtask

  task automatic test_single_press();
    int cnt;
    do_reset();
    exp_q.push_back(3'b001);
    fire_key = 1'b1;
    step();
    checks++;
    if ({create, slot_active, shots_free} !== {3'b001, 3'b001, 2'd2}) begin
      errors++;
      $display("FAIL single_launch: got c=%b a=%b f=%0d, required c=001 a=001 f=2",
               create, slot_active, shots_free);
    end
    fire_key = 1'b0;
    step();
    checks++;
    if (create !== 3'b000) begin
      errors++;
      $display("FAIL single_pulse_width: got %b, required 000", create);
    end
    cnt = 1;
    repeat (300) begin
      if (!slot_active[0]) break;
      cnt++;
      step();
    end
    checks++;
    if (cnt != 240) begin
      errors++;
      $display("FAIL single_lifetime: got %0d cycles, required 240", cnt);
    end
    checks++;
    if ({slot_active, shots_free} !== {3'b000, 2'd3}) begin
      errors++;
      $display("FAIL single_expired: got a=%b f=%0d, required a=000 f=3", slot_active, shots_free);
    end
    queue_drained("single");
  endtask

  task automatic test_four_presses_and_hit();
    logic [1:0] ef;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) exp_q.push_back(3'(1 << i));
      ef = (i < 3) ? 2'(2 - i) : 2'd0;
      fire_key = 1'b1;
      step();
      checks++;
      if ({fire_blocked, shots_free} !== {i == 3, ef}) begin
        errors++;
        $display("FAIL four_press%0d: got b=%b f=%0d, required b=%b f=%0d", i, fire_blocked, shots_free, i == 3, ef);
      end
      fire_key = 1'b0;
      step();
      checks++;
      if (fire_blocked !== 1'b0) begin
        errors++;
        $display("FAIL four_blocked_width%0d: got %b, required 0", i, fire_blocked);
      end
      step(18);
    end
    checks++;
    if (slot_active !== 3'b111) begin
      errors++;
      $display("FAIL four_all_active: got %b, required 111", slot_active);
    end
    slot_hit = 3'b010;
    step();
    slot_hit = 3'b000;
    checks++;
    if ({slot_active, shots_free} !== {3'b101, 2'd1}) begin
      errors++;
      $display("FAIL hit_release: got a=%b f=%0d, required a=101 f=1", slot_active, shots_free);
    end
    slot_hit = 3'b010;
    step();
    slot_hit = 3'b000;
    checks++;
    if (slot_active !== 3'b101) begin
      errors++;
      $display("FAIL hit_inactive: got %b, required 101", slot_active);
    end
    exp_q.push_back(3'b010);
    fire_key = 1'b1;
    step();
    checks++;
    if (slot_active !== 3'b111) begin
      errors++;
      $display("FAIL hit_realloc: got %b, required 111", slot_active);
    end
    slot_hit = 3'b010;
    fire_key = 1'b0;
    step();
    slot_hit = 3'b000;
    checks++;
    if (slot_active !== 3'b111) begin
      errors++;
      $display("FAIL hit_in_create_cycle: got %b, required 111", slot_active);
    end
    slot_hit = 3'b010;
    step();
    slot_hit = 3'b000;
    checks++;
    if (slot_active !== 3'b101) begin
      errors++;
      $display("FAIL hit_after_create: got %b, required 101", slot_active);
    end
    queue_drained("four");
  endtask

`ifndef SHOT_CONTROLLER_AUTOFIRE_EN
  task automatic test_cooldown();
    do_reset();
    exp_q.push_back(3'b001);
    fire_key = 1'b1;
    step();
    fire_key = 1'b0;
    step(4);
    fire_key = 1'b1;
    step();
    checks++;
    if (create !== 3'b000) begin
      errors++;
      $display("FAIL cooldown_press: got %b, required 000", create);
    end
    step(20);
    checks++;
    if ({slot_active, shots_free, fire_blocked} !== {3'b001, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL cooldown_held: got a=%b f=%0d b=%b, required a=001 f=2 b=0",
               slot_active, shots_free, fire_blocked);
    end
    fire_key = 1'b0;
    step();
    exp_q.push_back(3'b010);
    fire_key = 1'b1;
    step();
    checks++;
    if (slot_active !== 3'b011) begin
      errors++;
      $display("FAIL cooldown_repress: got %b, required 011", slot_active);
    end
    fire_key = 1'b0;
    step();
    queue_drained("cooldown");
  endtask
`else
  task automatic test_autofire();
    int got[$];
    int want[3] = '{1, 16, 31};
    do_reset();
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    fire_key = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (create !== 3'b000) got.push_back(i);
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL autofire_count: got %0d creates, required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] != want[i]) begin
          errors++;
          $display("FAIL autofire_cycle%0d: got %0d, required %0d", i, got[i], want[i]);
        end
      end
    end
    checks++;
    if ({shots_free, fire_blocked} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL autofire_full: got f=%0d b=%b, required f=0 b=0", shots_free, fire_blocked);
    end
    fire_key = 1'b0;
    step();
    queue_drained("autofire");
  endtask
`endif

  task automatic test_tank_dead();
    do_reset();
    tank_alive = 1'b0;
    fire_key = 1'b1;
    step();
    checks++;
    if ({create, slot_active, shots_free, fire_blocked} !== {3'b000, 3'b000, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL dead_press: got c=%b a=%b f=%0d b=%b, required c=000 a=000 f=3 b=0",
               create, slot_active, shots_free, fire_blocked);
    end
    fire_key = 1'b0;
    tank_alive = 1'b1;
    step();
    exp_q.push_back(3'b001);
    fire_key = 1'b1;
    step();
    checks++;
    if (slot_active !== 3'b001) begin
      errors++;
      $display("FAIL dead_then_alive: got %b, required 001", slot_active);
    end
    fire_key = 1'b0;
    step();
    queue_drained("dead");
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(3'(1 << i));
      fire_key = 1'b1;
      step();
      fire_key = 1'b0;
      step(19);
    end
    checks++;
    if (slot_active !== 3'b111) begin
      errors++;
      $display("FAIL areset_loaded: got %b, required 111", slot_active);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({create, slot_active, shots_free, fire_blocked} !== {3'b000, 3'b000, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL areset_outputs: got c=%b a=%b f=%0d b=%b, required c=000 a=000 f=3 b=0",
               create, slot_active, shots_free, fire_blocked);
    end
    step();
    Reset_n = 1'b1;
    step();
    exp_q.push_back(3'b001);
    fire_key = 1'b1;
    step();
    checks++;
    if ({slot_active, shots_free} !== {3'b001, 2'd2}) begin
      errors++;
      $display("FAIL areset_realloc: got a=%b f=%0d, required a=001 f=2", slot_active, shots_free);
    end
    fire_key = 1'b0;
    step();
    queue_drained("areset");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_four_presses_and_hit();
`ifndef SHOT_CONTROLLER_AUTOFIRE_EN
    test_cooldown();
`else
    test_autofire();
`endif
    test_tank_dead();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Upstream fire controller for one tank. Turns the player's shoot key into one-cycle create pulses, one per bullet slot, and supports up to NUM_BULLETS bullets on screen at once.
- Owns slot allocation, per-slot lifetime countdown, hit-based slot release and the inter-shot cooldown.
- Sits between the keyboard decode and the bullet instances. create[k] drives the create input of bullet instance k; slot_active[k] gates that instance's drawing and collision.

Parameters:
- NUM_BULLETS, 3, number of bullet slots (bullet instances) per tank.
- LIFE_FRAMES, 240, frames a bullet stays active after creation.
- COOLDOWN_FRAMES, 15, minimum frames from one create pulse to the next.

Ports:
- frame_clk  in  1  frame-rate clock; all state advances on its rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- fire_key  in  1  level-sensitive shoot key, already synchronised to frame_clk.
- tank_alive  in  1  when 0, no new shots; existing bullets continue.
- slot_hit  in  NUM_BULLETS  per-slot one-cycle pulse: bullet k hit a tank and must be retired.
- create  out  NUM_BULLETS  one-hot, one-cycle pulse that launches bullet k.
- slot_active  out  NUM_BULLETS  bullet k is in flight.
- shots_free  out  2  count of inactive slots (0..NUM_BULLETS).
- fire_blocked  out  1  one-cycle pulse: a press was rejected because all slots were busy.

Behaviour:
- Reset (async, Reset_n=0): create=0, slot_active=0, shots_free=NUM_BULLETS, fire_blocked=0, state=IDLE. All life and cooldown counters are 0 and the key history register is 0. This applies mid-flight too: all bullets are dropped immediately.
- Press detection: press = fire_key & ~key_q, where key_q is fire_key registered on each edge.
- State machine: IDLE, COOLDOWN, WAIT_RELEASE.
- IDLE:
  - On an edge with press & tank_alive and at least one free slot: choose the lowest-index free slot k. Register create[k]=1 for that one cycle only, set slot_active[k]=1, load life[k]=LIFE_FRAMES-1, load cd=COOLDOWN_FRAMES-1, go to COOLDOWN.
  - press & tank_alive with no free slot: fire_blocked pulses for 1 cycle, go to WAIT_RELEASE.
  - press while tank_alive=0: ignored, stay in IDLE.
- COOLDOWN:
  - cd decrements each edge.
  - On the edge where cd==0: go to WAIT_RELEASE if fire_key=1, else to IDLE.
  - Presses during COOLDOWN are discarded, not queued.
- WAIT_RELEASE: go to IDLE on the first edge with fire_key=0.
- Latency: create is asserted in the cycle immediately after the edge that samples the press (1 cycle).
- Lifetime:
  - While slot_active[k]=1 and life[k]!=0, life[k] decrements by 1 each edge.
  - On the edge where life[k]==0, slot_active[k] clears.
  - slot_active[k] is therefore high for exactly LIFE_FRAMES cycles, starting with the create cycle.
- Hit: slot_hit[k]=1 with slot_active[k]=1 clears slot_active[k] and life[k] on that edge. slot_hit on an inactive slot is ignored.
- Simultaneous events:
  - Hit and expiry on the same edge: the slot is freed once.
  - A slot freeing on edge E is not eligible for allocation on edge E; it becomes eligible from E+1.
  - A hit on slot k in the same cycle create[k] is high is ignored.
- Widths: life counters are $clog2(LIFE_FRAMES) bits; cd is $clog2(COOLDOWN_FRAMES) bits. Neither counter wraps; each stops at 0.
- shots_free = NUM_BULLETS - popcount(slot_active), registered consistently with slot_active.

Optional Feature:
- Macro: SHOT_CONTROLLER_AUTOFIRE_EN.
- Defined: in COOLDOWN on the cd==0 edge, if fire_key=1 & tank_alive and a slot is free, fire again directly (same allocation and create rules as IDLE) and reload cd. This gives one shot per COOLDOWN_FRAMES while the key is held. If no slot is free, stay in COOLDOWN holding cd=0 until a slot frees or the key is released; no fire_blocked pulse in this case.
- Not defined: one shot per press, as described above.

Decomposition:
- Package tank_pkg holds:
  - the NUM_BULLETS, LIFE_FRAMES and COOLDOWN_FRAMES defaults;
  - the shot_state_t enum {IDLE, COOLDOWN, WAIT_RELEASE};
  - the lowest-free-slot priority function.
- Sub-module bullet_life_timer: one instance per slot. Inputs load, hit; output active. It holds the life counter and the active flag. The top level holds the FSM, press detection, allocation and shots_free.

Test Plan:
- Reset_n low, then high; single press -> create=3'b001 for exactly 1 cycle, one cycle after the press edge; shots_free=2; slot_active[0] high 240 cycles, then low.
- Four presses spaced 20 cycles apart -> creates on slots 0, 1, 2 in order; 4th press gives fire_blocked 1-cycle pulse, no create, shots_free=0.
- slot_hit=3'b010 while slots 0-2 are active -> slot_active=3'b101 next cycle; next press allocates slot 1.
- Press, then second press 5 cycles later -> second press ignored (cooldown); key held through cd==0 -> WAIT_RELEASE, no fire until the key is released and pressed again.
- Reset_n pulsed low with 3 active bullets -> all outputs 0 asynchronously, shots_free=3, next press allocates slot 0.
- With SHOT_CONTROLLER_AUTOFIRE_EN defined, key held 100 cycles -> creates at cycles 1, 16, 31 on slots 0, 1, 2, then nothing until a slot frees.
